// File: rtl/idct_pkg.sv
// Shared constants, mode encoding and width helper
// for the pipelined 8-point IDCT.
package idct_pkg;

    localparam int C1_DEF = 251;
    localparam int C2_DEF = 236;
    localparam int C3_DEF = 213;
    localparam int C4_DEF = 181;
    localparam int C5_DEF = 142;
    localparam int C6_DEF = 98;
    localparam int C7_DEF = 50;

    typedef enum logic {
        MODE_PIXEL  = 1'b0,
        MODE_SIGNED = 1'b1
    } mode_e;

    function automatic int acc_w(input int in_w, input int coef_w);
        return in_w + coef_w + 3;
    endfunction

endpackage

// File: rtl/idct8_pipe_if.sv
// Valid/ready bus for idct8_pipe: coefficient beats in,
// clamped lanes out.
interface idct8_pipe_if
    import idct_pkg::*;
#(
    parameter int IN_W  = 11,
    parameter int OUT_W = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [8*IN_W-1:0]  in_data;
    mode_e              in_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [8*OUT_W-1:0] out_data;
    logic [7:0]         out_sat;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_sat, out_tag
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_sat, out_tag
    );
endinterface

// File: rtl/idct_round_clamp.sv
// One output lane: round half up at full width, optional
// level offset, then clamp to the mode's range.
module idct_round_clamp
    import idct_pkg::*;
#(
    parameter int A         = 23,
    parameter int OUT_W     = 8,
    parameter int FRAC      = 9,
    parameter int LEVEL_OFS = 0
) (
    input  logic signed [A-1:0] z_i,
    input  mode_e               mode_i,
    output logic [OUT_W-1:0]    lane_o,
    output logic                sat_o
);
    localparam int W = A + 2;
    localparam logic signed [W-1:0] HALF = W'(1) <<< (FRAC - 1);
    localparam logic signed [W-1:0] OFS  = W'(LEVEL_OFS);
    localparam logic signed [W-1:0] HI_P = W'((1 << OUT_W) - 1);
    localparam logic signed [W-1:0] HI_S = W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [W-1:0] LO_S = W'(-(1 << (OUT_W - 1)));

    logic signed [W-1:0] zx;
    logic signed [W-1:0] r;
    logic signed [W-1:0] v;
    logic signed [W-1:0] lo;
    logic signed [W-1:0] hi;

    always_comb begin
        zx = {{2{z_i[A-1]}}, z_i};
        r  = (zx + HALF) >>> FRAC;
        v  = r;
        lo = LO_S;
        hi = HI_S;
        if (mode_i == MODE_PIXEL) begin
            v  = r + OFS;
            lo = '0;
            hi = HI_P;
        end
        lane_o = v[OUT_W-1:0];
        sat_o  = 1'b0;
        unique case (1'b1)
            (v > hi): begin
                lane_o = hi[OUT_W-1:0];
                sat_o  = 1'b1;
            end
            (v < lo): begin
                lane_o = lo[OUT_W-1:0];
                sat_o  = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/idct8_pipe.sv
// Three-stage 8-point 1-D IDCT: products, even/odd sums,
// butterfly with round and clamp. One global stall enable.
module idct8_pipe
    import idct_pkg::*;
#(
    parameter int IN_W      = 11,
    parameter int COEF_W    = 9,
    parameter int OUT_W     = 8,
    parameter int FRAC      = 9,
    parameter int LEVEL_OFS = 0,
    parameter int TAG_W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    idct8_pipe_if.slave  bus
);
    localparam int A = acc_w(IN_W, COEF_W);
    localparam int NP = 22;

    localparam logic signed [A-1:0] K1 = A'(C1_DEF);
    localparam logic signed [A-1:0] K2 = A'(C2_DEF);
    localparam logic signed [A-1:0] K3 = A'(C3_DEF);
    localparam logic signed [A-1:0] K4 = A'(C4_DEF);
    localparam logic signed [A-1:0] K5 = A'(C5_DEF);
    localparam logic signed [A-1:0] K6 = A'(C6_DEF);
    localparam logic signed [A-1:0] K7 = A'(C7_DEF);

    logic en;

    logic signed [A-1:0] xe     [8];
    logic signed [A-1:0] prod_d [NP];
    logic signed [A-1:0] s1_p_q [NP];
    logic                s1_v_q;
    mode_e               s1_mode_q;
    logic [TAG_W-1:0]    s1_tag_q;

    logic signed [A-1:0] e_d  [4];
    logic signed [A-1:0] o_d  [4];
    logic signed [A-1:0] e_q  [4];
    logic signed [A-1:0] o_q  [4];
    logic                s2_v_q;
    mode_e               s2_mode_q;
    logic [TAG_W-1:0]    s2_tag_q;

    logic signed [A-1:0] z_d    [8];
    logic [OUT_W-1:0]    lane_d [8];
    logic [7:0]          sat_l;
    logic [8*OUT_W-1:0]  data_d;
    logic [7:0]          sat_d;

    logic                out_valid_q;
    logic [8*OUT_W-1:0]  out_data_q;
    logic [7:0]          out_sat_q;
    logic [TAG_W-1:0]    out_tag_q;

    assign en = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_tag   = out_tag_q;

    // Odd products sit at 6+4*j+k: x(2j+1) times c(2k+1).
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            xe[i] = {{(A-IN_W){bus.in_data[(7-i)*IN_W+IN_W-1]}},
                     bus.in_data[(7-i)*IN_W +: IN_W]};
        end
        prod_d[0] = K4 * xe[0];
        prod_d[1] = K4 * xe[4];
        prod_d[2] = K2 * xe[2];
        prod_d[3] = K6 * xe[2];
        prod_d[4] = K2 * xe[6];
        prod_d[5] = K6 * xe[6];
        for (int j = 0; j < 4; j++) begin
            prod_d[6+4*j] = K1 * xe[2*j+1];
            prod_d[7+4*j] = K3 * xe[2*j+1];
            prod_d[8+4*j] = K5 * xe[2*j+1];
            prod_d[9+4*j] = K7 * xe[2*j+1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
        end else if (en) begin
            s1_v_q    <= bus.in_valid;
            s1_p_q    <= prod_d;
            s1_mode_q <= bus.in_mode;
            s1_tag_q  <= bus.in_tag;
        end
    end

    always_comb begin
        e_d[0] = s1_p_q[0] + s1_p_q[1] + s1_p_q[2] + s1_p_q[5];
        e_d[1] = s1_p_q[0] - s1_p_q[1] + s1_p_q[3] - s1_p_q[4];
        e_d[2] = s1_p_q[0] - s1_p_q[1] - s1_p_q[3] + s1_p_q[4];
        e_d[3] = s1_p_q[0] + s1_p_q[1] - s1_p_q[2] - s1_p_q[5];
        o_d[0] = s1_p_q[6] + s1_p_q[11] + s1_p_q[16] + s1_p_q[21];
        o_d[1] = s1_p_q[7] - s1_p_q[13] - s1_p_q[14] - s1_p_q[20];
        o_d[2] = s1_p_q[8] - s1_p_q[10] + s1_p_q[17] + s1_p_q[19];
        o_d[3] = s1_p_q[9] - s1_p_q[12] + s1_p_q[15] - s1_p_q[18];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
        end else if (en) begin
            s2_v_q    <= s1_v_q;
            e_q       <= e_d;
            o_q       <= o_d;
            s2_mode_q <= s1_mode_q;
            s2_tag_q  <= s1_tag_q;
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            z_d[n]   = e_q[n] + o_q[n];
            z_d[7-n] = e_q[n] - o_q[n];
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_lane
        idct_round_clamp #(
            .A         (A),
            .OUT_W     (OUT_W),
            .FRAC      (FRAC),
            .LEVEL_OFS (LEVEL_OFS)
        ) u_rc (
            .z_i    (z_d[g]),
            .mode_i (s2_mode_q),
            .lane_o (lane_d[g]),
            .sat_o  (sat_l[g])
        );
    end

    always_comb begin
        data_d = '0;
        sat_d  = '0;
        for (int i = 0; i < 8; i++) begin
            data_d[(7-i)*OUT_W +: OUT_W] = lane_d[i];
            sat_d[7-i] = sat_l[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
            out_tag_q   <= '0;
        end else if (en) begin
            out_valid_q <= s2_v_q;
            if (s2_v_q) begin
                out_data_q <= data_d;
                out_sat_q  <= sat_d;
                out_tag_q  <= s2_tag_q;
            end
        end
    end
endmodule

// File: tb/tb_idct8_pipe.sv
// Directed bench for idct8_pipe: DC, rounding edges, odd
// lanes, backpressure and mid-flight reset.
module tb_idct8_pipe;
    import idct_pkg::*;

    localparam int IN_W  = 11;
    localparam int OUT_W = 8;
    localparam int TAG_W = 4;
    localparam int FRAC  = 9;
    localparam int LOFS  = 0;

    typedef logic [8*IN_W-1:0]  din_t;
    typedef logic [8*OUT_W-1:0] dout_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    idct8_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    idct8_pipe #(
        .IN_W      (IN_W),
        .COEF_W    (9),
        .OUT_W     (OUT_W),
        .FRAC      (FRAC),
        .LEVEL_OFS (LOFS),
        .TAG_W     (TAG_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic din_t lane1(input int lane, input int val);
        din_t d;
        logic [IN_W-1:0] v;
        d = '0;
        v = val[IN_W-1:0];
        d[(7-lane)*IN_W +: IN_W] = v;
        return d;
    endfunction

    // Straight integer evaluation of the IDCT equations.
    function automatic void model(input din_t d, input logic m,
                                  output dout_t od, output logic [7:0] os);
        int x[8];
        int e[4];
        int o[4];
        int z[8];
        int r, v, lo, hi;
        int c1, c2, c3, c4, c5, c6, c7;
        c1 = 251; c2 = 236; c3 = 213; c4 = 181;
        c5 = 142; c6 = 98;  c7 = 50;
        for (int i = 0; i < 8; i++)
            x[i] = int'($signed(d[(7-i)*IN_W +: IN_W]));
        e[0] = c4*x[0] + c4*x[4] + c2*x[2] + c6*x[6];
        e[1] = c4*x[0] - c4*x[4] + c6*x[2] - c2*x[6];
        e[2] = c4*x[0] - c4*x[4] - c6*x[2] + c2*x[6];
        e[3] = c4*x[0] + c4*x[4] - c2*x[2] - c6*x[6];
        o[0] = c1*x[1] + c3*x[3] + c5*x[5] + c7*x[7];
        o[1] = c3*x[1] - c7*x[3] - c1*x[5] - c5*x[7];
        o[2] = c5*x[1] - c1*x[3] + c7*x[5] + c3*x[7];
        o[3] = c7*x[1] - c5*x[3] + c3*x[5] - c1*x[7];
        for (int n = 0; n < 4; n++) begin
            z[n]   = e[n] + o[n];
            z[7-n] = e[n] - o[n];
        end
        od = '0;
        os = '0;
        for (int i = 0; i < 8; i++) begin
            r = (z[i] + (1 << (FRAC - 1))) >>> FRAC;
            if (m == 1'b0) begin
                v = r + LOFS; lo = 0; hi = 255;
            end else begin
                v = r; lo = -128; hi = 127;
            end
            if (v > hi) begin v = hi; os[7-i] = 1'b1; end
            if (v < lo) begin v = lo; os[7-i] = 1'b1; end
            od[(7-i)*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
    endfunction

    task automatic run_single(input din_t d, input logic m,
                              input logic [TAG_W-1:0] t,
                              output dout_t od, output logic [7:0] os,
                              output logic [TAG_W-1:0] ot, output int lat);
        bus.in_data   = d;
        bus.in_mode   = m ? MODE_SIGNED : MODE_PIXEL;
        bus.in_tag    = t;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        od = bus.out_data;
        os = bus.out_sat;
        ot = bus.out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b1;
        bus.in_data   = lane1(0, 256);
        bus.in_mode   = MODE_PIXEL;
        bus.in_tag    = 4'd9;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
        end
        total++;
        if (bus.out_data !== '0 || bus.out_sat !== '0 || bus.out_tag !== '0) begin
            bad++;
            $display("FAIL reset_outs got=%h/%h/%h exp=0/0/0",
                     bus.out_data, bus.out_sat, bus.out_tag);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                if (bus.out_valid) seen++;
                @(posedge clk); #1;
            end
            total++;
            if (seen != 0) begin
                bad++; $display("FAIL reset_discard got=%0d exp=0", seen);
            end
        end
    endtask

    task automatic test_dc();
        dout_t od; logic [7:0] os; logic [TAG_W-1:0] ot; int lat;
        run_single(lane1(0, 256), 1'b0, 4'd1, od, os, ot, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL dc_latency got=%0d exp=3", lat); end
        total++;
        if (od !== {8{8'h5B}} || os !== 8'h00) begin
            bad++; $display("FAIL dc_pos got=%h sat=%h exp=%h sat=00", od, os, {8{8'h5B}});
        end
        total++;
        if (ot !== 4'd1) begin bad++; $display("FAIL dc_tag got=%0d exp=1", ot); end
        run_single(lane1(0, -256), 1'b0, 4'd2, od, os, ot, lat);
        total++;
        if (od !== 64'h0 || os !== 8'hFF) begin
            bad++; $display("FAIL dc_neg_m0 got=%h sat=%h exp=0 sat=ff", od, os);
        end
        run_single(lane1(0, -256), 1'b1, 4'd3, od, os, ot, lat);
        total++;
        if (od !== {8{8'hA6}} || os !== 8'h00) begin
            bad++; $display("FAIL dc_neg_m1 got=%h sat=%h exp=%h sat=00", od, os, {8{8'hA6}});
        end
    endtask

    task automatic test_round();
        dout_t od; logic [7:0] os; logic [TAG_W-1:0] ot; int lat;
        run_single(lane1(0, 722), 1'b0, 4'd4, od, os, ot, lat);
        total++;
        if (od !== {8{8'hFF}} || os !== 8'h00) begin
            bad++; $display("FAIL round_722 got=%h sat=%h exp=ff.. sat=00", od, os);
        end
        run_single(lane1(0, 723), 1'b0, 4'd5, od, os, ot, lat);
        total++;
        if (od !== {8{8'hFF}} || os !== 8'hFF) begin
            bad++; $display("FAIL round_723 got=%h sat=%h exp=ff.. sat=ff", od, os);
        end
        run_single(lane1(0, 1023), 1'b1, 4'd6, od, os, ot, lat);
        total++;
        if (od !== {8{8'h7F}} || os !== 8'hFF) begin
            bad++; $display("FAIL round_1023_m1 got=%h sat=%h exp=7f.. sat=ff", od, os);
        end
    endtask

    task automatic test_nondc();
        dout_t od; logic [7:0] os; logic [TAG_W-1:0] ot; int lat;
        dout_t exp_d;
        exp_d = {8'h31, 8'h2A, 8'h1C, 8'h0A, 8'hF6, 8'hE4, 8'hD6, 8'hCF};
        run_single(lane1(1, 100), 1'b1, 4'd7, od, os, ot, lat);
        total++;
        if (od !== exp_d || os !== 8'h00) begin
            bad++; $display("FAIL nondc_x1 got=%h sat=%h exp=%h sat=00", od, os, exp_d);
        end
    endtask

    task automatic test_back_to_back();
        din_t bd[5];
        logic bm[5];
        dout_t ed, prev_d;
        logic [7:0] es;
        logic [TAG_W-1:0] prev_t;
        logic prev_stall;
        int sent, rcvd, extra;
        for (int t = 0; t < 5; t++) begin
            bd[t] = '0;
            for (int i = 0; i < 8; i++)
                bd[t] = bd[t] | lane1(i, ((t*97 + i*211 + 13) % 2047) - 1023);
            bm[t] = t[0];
        end
        sent = 0; rcvd = 0; prev_stall = 1'b0;
        prev_d = '0; prev_t = '0;
        for (int c = 0; c < 60 && rcvd < 5; c++) begin
            bus.out_ready = !(c >= 2 && c <= 8);
            if (sent < 5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = bd[sent];
                bus.in_mode  = bm[sent] ? MODE_SIGNED : MODE_PIXEL;
                bus.in_tag   = TAG_W'(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                total++;
                if (bus.out_data !== prev_d || bus.out_tag !== prev_t) begin
                    bad++;
                    $display("FAIL bp_hold got=%h/%0d exp=%h/%0d",
                             bus.out_data, bus.out_tag, prev_d, prev_t);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                total++;
                if (bus.in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, bus.in_ready);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (bus.out_tag !== TAG_W'(rcvd)) begin
                    bad++; $display("FAIL bp_order got=%0d exp=%0d", bus.out_tag, rcvd);
                end
                model(bd[rcvd], bm[rcvd], ed, es);
                total++;
                if (bus.out_data !== ed || bus.out_sat !== es) begin
                    bad++;
                    $display("FAIL bp_data beat=%0d got=%h sat=%h exp=%h sat=%h",
                             rcvd, bus.out_data, bus.out_sat, ed, es);
                end
                rcvd++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_d = bus.out_data;
            prev_t = bus.out_tag;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        total++;
        if (rcvd != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", rcvd); end
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) extra++;
            @(posedge clk); #1;
        end
        total++;
        if (extra != 0) begin bad++; $display("FAIL bp_dup got=%0d exp=0", extra); end
    endtask

    task automatic test_reset_midflight();
        dout_t od; logic [7:0] os; logic [TAG_W-1:0] ot; int lat;
        int seen;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = lane1(0, 256);
        bus.in_mode   = MODE_PIXEL;
        bus.in_tag    = 4'd10;
        @(posedge clk); #1;
        bus.in_data = lane1(1, 100);
        bus.in_mode = MODE_SIGNED;
        bus.in_tag  = 4'd11;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            bad++;
            $display("FAIL mid_reset got=%b/%h exp=0/0", bus.out_valid, bus.out_data);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL mid_ghost got=%0d exp=0", seen); end
        run_single(lane1(0, -256), 1'b1, 4'd12, od, os, ot, lat);
        total++;
        if (lat != 3) begin bad++; $display("FAIL mid_latency got=%0d exp=3", lat); end
        total++;
        if (od !== {8{8'hA6}} || ot !== 4'd12) begin
            bad++; $display("FAIL mid_new got=%h/%0d exp=%h/12", od, ot, {8{8'hA6}});
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = MODE_PIXEL;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_dc();
        test_round();
        test_nondc();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
